// File: rtl/xgmii_rx_link_monitor_pkg.sv
// Shared XGMII RX monitor definitions: control characters, fault codes, link FSM encoding
// and the sequence ordered-set column decoder.
package xgmii_rx_link_monitor_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [7:0] XGMII_SEQ   = 8'h9C;

    localparam logic [7:0] FAULT_LF = 8'h01;
    localparam logic [7:0] FAULT_RF = 8'h02;

    typedef enum logic [1:0] {
        ST_DOWN    = 2'd0,
        ST_LOCKING = 2'd1,
        ST_UP      = 2'd2,
        ST_FAULT   = 2'd3
    } link_state_e;

    typedef enum logic [1:0] {
        SEQ_NONE = 2'd0,
        SEQ_LF   = 2'd1,
        SEQ_RF   = 2'd2
    } seq_type_e;

    // One 4-lane column: /Q/ in lane 0, data lanes 1-3, zeros in lanes 1-2, fault code in lane 3.
    function automatic seq_type_e decode_column(input logic [31:0] col_d, input logic [3:0] col_c);
        seq_type_e t;
        t = SEQ_NONE;
        if (col_c == 4'b0001 && col_d[7:0] == XGMII_SEQ && col_d[23:8] == 16'h0000) begin
            if (col_d[31:24] == FAULT_LF) begin
                t = SEQ_LF;
            end else if (col_d[31:24] == FAULT_RF) begin
                t = SEQ_RF;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/xgmii_fault_tracker.sv
// Clause 46 sequence-set fault tracker: counts consecutive same-type sequences and the gap since the last one.
// Registered fault outputs one cycle after the input; next-state values also exported; passive, no backpressure.
module xgmii_fault_tracker
    import xgmii_rx_link_monitor_pkg::*;
#(
    parameter int FAULT_SEQ_COUNT = 4,
    parameter int FAULT_WINDOW    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        track_i,
    input  logic [63:0] rxd_i,
    input  logic [7:0]  rxc_i,
    output logic        local_fault_d_o,
    output logic        remote_fault_d_o,
    output logic        local_fault_o,
    output logic        remote_fault_o
);

    localparam int SEQ_W = $clog2(FAULT_SEQ_COUNT + 1);
    localparam int GAP_W = $clog2(FAULT_WINDOW + 1);
    localparam logic [SEQ_W-1:0] SEQ_MAX = SEQ_W'(FAULT_SEQ_COUNT);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(FAULT_WINDOW);

    seq_type_e          seq_lo, seq_hi, seq_now;
    seq_type_e          type_q, type_d;
    logic [SEQ_W-1:0]   seq_cnt_q, seq_cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               lf_q, lf_d, rf_q, rf_d;

    assign seq_lo  = decode_column(rxd_i[31:0], rxc_i[3:0]);
    assign seq_hi  = decode_column(rxd_i[63:32], rxc_i[7:4]);
    assign seq_now = (seq_hi != SEQ_NONE) ? seq_hi : seq_lo;

    always_comb begin
        type_d    = type_q;
        seq_cnt_d = seq_cnt_q;
        gap_d     = gap_q;
        lf_d      = lf_q;
        rf_d      = rf_q;
        if (!track_i) begin
            type_d    = SEQ_NONE;
            seq_cnt_d = '0;
            gap_d     = '0;
            lf_d      = 1'b0;
            rf_d      = 1'b0;
        end else if (seq_now != SEQ_NONE) begin
            gap_d = '0;
            if (seq_now == type_q && gap_q < GAP_MAX) begin
                if (seq_cnt_q != SEQ_MAX) begin
                    seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                end
            end else begin
                seq_cnt_d = SEQ_W'(1);
                type_d    = seq_now;
            end
            // Declaring one fault always retracts the other.
            if (seq_cnt_d == SEQ_MAX) begin
                lf_d = (type_d == SEQ_LF);
                rf_d = (type_d == SEQ_RF);
            end
        end else begin
            if (gap_q != GAP_MAX) begin
                gap_d = gap_q + GAP_W'(1);
            end
            if (gap_d == GAP_MAX) begin
                lf_d      = 1'b0;
                rf_d      = 1'b0;
                seq_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            type_q    <= SEQ_NONE;
            seq_cnt_q <= '0;
            gap_q     <= '0;
            lf_q      <= 1'b0;
            rf_q      <= 1'b0;
        end else begin
            type_q    <= type_d;
            seq_cnt_q <= seq_cnt_d;
            gap_q     <= gap_d;
            lf_q      <= lf_d;
            rf_q      <= rf_d;
        end
    end

    assign local_fault_d_o  = lf_d;
    assign remote_fault_d_o = rf_d;
    assign local_fault_o    = lf_q;
    assign remote_fault_o   = rf_q;

endmodule

// File: rtl/xgmii_rx_link_monitor.sv
// Passive XGMII RX monitor: link qualification FSM, fault state, frame/error counters, activity stretcher.
// All outputs registered, one cycle after the sampled input; never backpressures the data path.
module xgmii_rx_link_monitor
    import xgmii_rx_link_monitor_pkg::*;
#(
    parameter int LOCK_CYCLES     = 156250,
    parameter int FAULT_SEQ_COUNT = 4,
    parameter int FAULT_WINDOW    = 64,
    parameter int ACT_STRETCH     = 1562500,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [63:0]          xgmii_rxd,
    input  logic [7:0]           xgmii_rxc,
    input  logic                 rx_block_lock,
    output logic                 link_up,
    output logic                 local_fault,
    output logic                 remote_fault,
    output logic                 rx_activity,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] error_count
);

    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int ACT_W  = $clog2(ACT_STRETCH + 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [ACT_W-1:0]  ACT_LOAD  = ACT_W'(ACT_STRETCH - 1);

    link_state_e          state_q;
    logic [LOCK_W-1:0]    lock_cnt_q;
    logic                 link_up_q;
    logic [CNT_WIDTH-1:0] frame_cnt_q, error_cnt_q;
    logic [ACT_W-1:0]     act_cnt_q;
    logic                 rx_activity_q;
    logic                 track, start_seen, err_seen, err_any;
    logic                 lf_next, rf_next;

    // Data is only observed once the link has qualified and lock is still present this cycle.
    assign track = rx_block_lock && (state_q == ST_UP || state_q == ST_FAULT);

    assign start_seen = track &&
        ((xgmii_rxc[0] && xgmii_rxd[7:0] == XGMII_START) ||
         (xgmii_rxc[4] && xgmii_rxd[39:32] == XGMII_START));

    always_comb begin
        err_any = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (xgmii_rxc[n] && xgmii_rxd[8*n +: 8] == XGMII_ERROR) begin
                err_any = 1'b1;
            end
        end
    end

    assign err_seen = track && err_any;

    xgmii_fault_tracker #(
        .FAULT_SEQ_COUNT (FAULT_SEQ_COUNT),
        .FAULT_WINDOW    (FAULT_WINDOW)
    ) u_fault_tracker (
        .clk              (clk),
        .rst              (rst),
        .track_i          (track),
        .rxd_i            (xgmii_rxd),
        .rxc_i            (xgmii_rxc),
        .local_fault_d_o  (lf_next),
        .remote_fault_d_o (rf_next),
        .local_fault_o    (local_fault),
        .remote_fault_o   (remote_fault)
    );

    // FSM follows the tracker's next-state faults so link_up drops in step with the fault outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_DOWN;
            lock_cnt_q <= '0;
            link_up_q  <= 1'b0;
        end else if (!rx_block_lock) begin
            state_q    <= ST_DOWN;
            lock_cnt_q <= '0;
            link_up_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_DOWN: begin
                    state_q    <= ST_LOCKING;
                    lock_cnt_q <= '0;
                end
                ST_LOCKING: begin
                    if (lock_cnt_q == LOCK_LAST) begin
                        state_q   <= ST_UP;
                        link_up_q <= 1'b1;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
                    end
                end
                ST_UP: begin
                    if (lf_next || rf_next) begin
                        state_q   <= ST_FAULT;
                        link_up_q <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    if (!lf_next && !rf_next) begin
                        state_q   <= ST_UP;
                        link_up_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_DOWN;
                    link_up_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q   <= '0;
            error_cnt_q   <= '0;
            act_cnt_q     <= '0;
            rx_activity_q <= 1'b0;
        end else begin
            if (start_seen) begin
                frame_cnt_q <= frame_cnt_q + CNT_WIDTH'(1);
            end
            if (err_seen) begin
                error_cnt_q <= error_cnt_q + CNT_WIDTH'(1);
            end
            if (start_seen) begin
                act_cnt_q <= ACT_LOAD;
            end else if (act_cnt_q != '0) begin
                act_cnt_q <= act_cnt_q - ACT_W'(1);
            end
            // High in the start cycle plus ACT_STRETCH-1 countdown cycles.
            rx_activity_q <= start_seen || (act_cnt_q != '0);
        end
    end

    assign link_up     = link_up_q;
    assign rx_activity = rx_activity_q;
    assign frame_count = frame_cnt_q;
    assign error_count = error_cnt_q;

endmodule

// File: tb/tb_xgmii_rx_link_monitor.sv
// Scoreboarded bench for xgmii_rx_link_monitor: directed scenarios plus randomized XGMII traffic
// checked against a timestamp-based reference model.
module tb_xgmii_rx_link_monitor;

    localparam int LC   = 16;
    localparam int NSEQ = 4;
    localparam int WIN  = 64;
    localparam int STR  = 20;
    localparam int CW   = 4;
    localparam logic [63:0] IDLE   = 64'h0707070707070707;
    localparam logic [31:0] IDLE32 = 32'h07070707;
    localparam int NEVER = -1000000;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   rxd;
    logic [7:0]    rxc;
    logic          lock;
    logic          link_up, local_fault, remote_fault, rx_activity;
    logic [CW-1:0] frame_count, error_count;

    always #5 clk = ~clk;

    xgmii_rx_link_monitor #(
        .LOCK_CYCLES     (LC),
        .FAULT_SEQ_COUNT (NSEQ),
        .FAULT_WINDOW    (WIN),
        .ACT_STRETCH     (STR),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .xgmii_rxd     (rxd),
        .xgmii_rxc     (rxc),
        .rx_block_lock (lock),
        .link_up       (link_up),
        .local_fault   (local_fault),
        .remote_fault  (remote_fault),
        .rx_activity   (rx_activity),
        .frame_count   (frame_count),
        .error_count   (error_count)
    );

    typedef struct {
        int up;
        int lf;
        int rf;
        int act;
        int fc;
        int ec;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Reference model state: timestamps and run lengths rather than counters.
    int t = 0;
    int lock_run, fault, run_type, run_len, last_seq, last_start, fcnt, ecnt;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, req, t);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("link_up", int'(link_up), mon_e.up);
            chk("local_fault", int'(local_fault), mon_e.lf);
            chk("remote_fault", int'(remote_fault), mon_e.rf);
            chk("rx_activity", int'(rx_activity), mon_e.act);
            chk("frame_count", int'(frame_count), mon_e.fc);
            chk("error_count", int'(error_count), mon_e.ec);
        end
    end

    task automatic model_reset();
        lock_run   = 0;
        fault      = 0;
        run_type   = 0;
        run_len    = 0;
        last_seq   = NEVER;
        last_start = NEVER;
        fcnt       = 0;
        ecnt       = 0;
    endtask

    // Returns fault code of the winning column (lane 4 column overrides lane 0), 0 if none.
    function automatic int seq_of(input logic [63:0] d, input logic [7:0] c);
        int r = 0;
        for (int col = 0; col < 2; col++) begin
            int b = col * 4;
            logic [7:0] code = d[8*b+24 +: 8];
            if (c[b] && !c[b+1] && !c[b+2] && !c[b+3] && d[8*b +: 8] == 8'h9C &&
                d[8*b+8 +: 16] == 16'h0000 && (code == 8'h01 || code == 8'h02))
                r = int'(code);
        end
        return r;
    endfunction

    task automatic model_cycle(input logic [63:0] d, input logic [7:0] c, input logic l, output exp_t e);
        int  seq;
        bit  start, err;
        if (!l) begin
            lock_run = 0;
        end else if (lock_run < 1000000) begin
            lock_run++;
        end
        if (l && lock_run >= LC + 2) begin
            seq   = seq_of(d, c);
            start = (c[0] && d[7:0] == 8'hFB) || (c[4] && d[39:32] == 8'hFB);
            err   = 1'b0;
            for (int n = 0; n < 8; n++)
                if (c[n] && d[8*n +: 8] == 8'hFE) err = 1'b1;
            if (start) begin
                fcnt       = (fcnt + 1) % (1 << CW);
                last_start = t;
            end
            if (err) ecnt = (ecnt + 1) % (1 << CW);
            if (seq != 0) begin
                if (seq == run_type && (t - last_seq - 1) < WIN) begin
                    if (run_len < NSEQ) run_len++;
                end else begin
                    run_len  = 1;
                    run_type = seq;
                end
                last_seq = t;
                if (run_len == NSEQ) fault = run_type;
            end else if (t - last_seq == WIN) begin
                fault   = 0;
                run_len = 0;
            end
        end else begin
            fault    = 0;
            run_type = 0;
            run_len  = 0;
            last_seq = NEVER;
        end
        e.up  = (lock_run >= LC + 1 && fault == 0) ? 1 : 0;
        e.lf  = (fault == 1) ? 1 : 0;
        e.rf  = (fault == 2) ? 1 : 0;
        e.act = ((t - last_start) < STR) ? 1 : 0;
        e.fc  = fcnt;
        e.ec  = ecnt;
        t++;
    endtask

    task automatic step(input logic [63:0] d, input logic [7:0] c, input logic l);
        exp_t e;
        @(negedge clk);
        rxd  = d;
        rxc  = c;
        lock = l;
        @(posedge clk);
        model_cycle(d, c, l, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(IDLE, 8'hFF, 1'b1);
    endtask

    function automatic logic [31:0] seq_col(input int code);
        return {8'(code), 16'h0000, 8'h9C};
    endfunction

    task automatic async_reset_check();
        @(negedge clk);
        #2;
        rst  = 1'b1;
        lock = 1'b0;
        rxd  = IDLE;
        rxc  = 8'hFF;
        #1;
        chk("rst_link_up", int'(link_up), 0);
        chk("rst_local_fault", int'(local_fault), 0);
        chk("rst_remote_fault", int'(remote_fault), 0);
        chk("rst_rx_activity", int'(rx_activity), 0);
        chk("rst_frame_count", int'(frame_count), 0);
        chk("rst_error_count", int'(error_count), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int          r, ty, prev_ty, code, ln, seq_pct, drop;
        logic [63:0] d;
        logic [7:0]  c;

        rst  = 1'b0;
        lock = 1'b0;
        rxd  = IDLE;
        rxc  = 8'hFF;
        model_reset();
        async_reset_check();

        // Qualification, then a one-cycle lock drop and requalification.
        idle(20);
        step(IDLE, 8'hFF, 1'b0);
        idle(20);

        // Four local-fault sequences ten cycles apart, then the window expires.
        for (int i = 0; i < 4; i++) begin
            step({IDLE32, seq_col(1)}, 8'hF1, 1'b1);
            idle(9);
        end
        idle(70);

        // Alternating types never reach the threshold; then remote fault via lane 4.
        for (int i = 0; i < 8; i++) begin
            step({IDLE32, seq_col((i % 2 == 0) ? 1 : 2)}, 8'hF1, 1'b1);
            idle(2);
        end
        for (int i = 0; i < 4; i++) begin
            step({seq_col(2), IDLE32}, 8'h1F, 1'b1);
            idle(4);
        end
        idle(70);

        // Three frame starts across both lanes and one error cycle, then let activity lapse.
        step({IDLE32, 32'h555555FB}, 8'hF1, 1'b1);
        idle(3);
        step({32'h555555FB, IDLE32}, 8'h1F, 1'b1);
        idle(3);
        step({IDLE32, 32'h555555FB}, 8'hF1, 1'b1);
        step(64'h0707FE0707FE0707, 8'hFF, 1'b1);
        idle(STR + 5);

        // Enough starts to wrap the counter, including a cycle with both lanes starting.
        for (int i = 0; i < 14; i++) step({IDLE32, 32'h555555FB}, 8'hF1, 1'b1);
        step({32'h555555FB, 32'h555555FB}, 8'h11, 1'b1);
        idle(3);

        prev_ty = 1;
        for (int seg = 0; seg < 14; seg++) begin
            seq_pct = (seg % 2 == 1) ? 25 : 2;
            drop    = 0;
            for (int i = 0; i < 200; i++) begin
                r = $urandom_range(0, 99);
                d = IDLE;
                c = 8'hFF;
                if (r < seq_pct) begin
                    ty      = ($urandom_range(0, 9) < 7) ? prev_ty : 3 - prev_ty;
                    prev_ty = ty;
                    code    = ($urandom_range(0, 9) == 0) ? 3 : ty;
                    ln      = $urandom_range(0, 2);
                    if (ln == 0) begin
                        d[31:0] = seq_col(code);
                        c       = 8'hF1;
                    end else if (ln == 1) begin
                        d[63:32] = seq_col(code);
                        c        = 8'h1F;
                    end else begin
                        d = {seq_col(code), seq_col(3 - ty)};
                        c = 8'h11;
                    end
                end else if (r < seq_pct + 10) begin
                    d = {$urandom, $urandom};
                    c = 8'h00;
                    if ($urandom_range(0, 1) == 0) begin
                        d[7:0] = 8'hFB;
                        c[0]   = 1'b1;
                    end else begin
                        d[39:32] = 8'hFB;
                        c[4]     = 1'b1;
                    end
                end else if (r < seq_pct + 15) begin
                    ln            = $urandom_range(0, 7);
                    d[8*ln +: 8]  = 8'hFE;
                end else if (r < seq_pct + 25) begin
                    d = {$urandom, $urandom};
                    c = 8'($urandom);
                end
                if (drop == 0 && $urandom_range(0, 299) == 0) drop = $urandom_range(1, 3);
                if (drop > 0) begin
                    drop--;
                    step(d, c, 1'b0);
                end else begin
                    step(d, c, 1'b1);
                end
            end
        end

        // Mid-fault, mid-stretch asynchronous reset.
        idle(20);
        for (int i = 0; i < 4; i++) begin
            step({IDLE32, seq_col(1)}, 8'hF1, 1'b1);
            idle(1);
        end
        step({IDLE32, 32'h555555FB}, 8'hF1, 1'b1);
        idle(3);
        @(negedge clk);
        chk("pre_rst_local_fault", int'(local_fault), 1);
        chk("pre_rst_rx_activity", int'(rx_activity), 1);
        async_reset_check();
        idle(25);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        chk("queue_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
